// File: rtl/registros_pkg.sv
// Shared port map and status bit positions for the PicoBlaze register read/write decoders.
package registros_pkg;

  localparam logic [7:0] PORT_SEG_HORA   = 8'h03;
  localparam logic [7:0] PORT_MIN_HORA   = 8'h04;
  localparam logic [7:0] PORT_HORA_HORA  = 8'h05;
  localparam logic [7:0] PORT_DIA_FECHA  = 8'h06;
  localparam logic [7:0] PORT_MES_FECHA  = 8'h07;
  localparam logic [7:0] PORT_JAHR_FECHA = 8'h08;
  localparam logic [7:0] PORT_SEG_TIMER  = 8'h0A;
  localparam logic [7:0] PORT_MIN_TIMER  = 8'h0B;
  localparam logic [7:0] PORT_HORA_TIMER = 8'h0C;
  localparam logic [7:0] PORT_BANDERAS   = 8'h0D;
  localparam logic [7:0] PORT_STATUS_DEF = 8'h0E;

  localparam int RTC_BYTES     = 6;
  localparam int TMR_BYTES     = 3;
  localparam int BIT_TIMER_FIN = 0;
  localparam int BIT_ALARMA    = 1;

  function automatic logic [7:0] status_byte(input logic [1:0] sticky);
    return {6'b000000, sticky};
  endfunction

endpackage

// File: rtl/mux_lectura_registros_if.sv
// PicoBlaze input-port bus: address and strobe from the CPU, read data and interrupt back to it.
interface mux_lectura_registros_if;
  logic [7:0] port_id;
  logic       read_strobe;
  logic [7:0] in_port;
  logic       irq;

  modport master (output port_id, output read_strobe, input in_port, input irq);
  modport slave  (input port_id, input read_strobe, output in_port, output irq);
endinterface

// File: rtl/snapshot_grupo.sv
// N-byte load-enable register bank with asynchronous active-low reset.
module snapshot_grupo #(
  parameter int N = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [N-1:0][7:0] d,
  output logic [N-1:0][7:0] q
);

  logic [N-1:0][7:0] dato_q;
  logic [N-1:0][7:0] dato_d;

  always_comb begin
    dato_d = dato_q;
    if (load) dato_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dato_q <= '0;
    else        dato_q <= dato_d;
  end

  assign q = dato_q;

endmodule

// File: rtl/mux_lectura_registros.sv
// PicoBlaze read mux with coherent RTC/timer snapshots and sticky event status driving irq.
// Snapshots are built only when LECTURA_SNAPSHOT_EN is defined; otherwise every port reads live.
module mux_lectura_registros
  import registros_pkg::*;
#(
  parameter logic [7:0] STATUS_PORT = PORT_STATUS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  mux_lectura_registros_if.slave       bus,
  input  logic [7:0]                   seg_hora,
  input  logic [7:0]                   min_hora,
  input  logic [7:0]                   hora_hora,
  input  logic [7:0]                   dia_fecha,
  input  logic [7:0]                   mes_fecha,
  input  logic [7:0]                   jahr_fecha,
  input  logic [7:0]                   seg_timer,
  input  logic [7:0]                   min_timer,
  input  logic [7:0]                   hora_timer,
  input  logic [7:0]                   banderas_config,
  input  logic                         timer_fin,
  input  logic                         alarma
);

  logic [RTC_BYTES-1:0][7:0] rtc_live, rtc_view;
  logic [TMR_BYTES-1:0][7:0] tmr_live, tmr_view;
  logic [7:0] in_port_q, in_port_d;
  logic [1:0] sticky_q, sticky_d;
  logic       irq_q, irq_d;
  logic       clr_status;

  assign rtc_live = {jahr_fecha, mes_fecha, dia_fecha, hora_hora, min_hora, seg_hora};
  assign tmr_live = {hora_timer, min_timer, seg_timer};

`ifdef LECTURA_SNAPSHOT_EN
  logic arm_rtc, arm_tmr;
  logic [RTC_BYTES-1:0][7:0] rtc_snap;
  logic [TMR_BYTES-1:0][7:0] tmr_snap;

  // An arm cycle is the first INPUT cycle on the lowest byte of a group.
  assign arm_rtc = (bus.port_id == PORT_SEG_HORA)  && !bus.read_strobe;
  assign arm_tmr = (bus.port_id == PORT_SEG_TIMER) && !bus.read_strobe;

  snapshot_grupo #(.N(RTC_BYTES)) u_snap_rtc (
    .clk(clk), .rst_n(rst_n), .load(arm_rtc), .d(rtc_live), .q(rtc_snap)
  );

  snapshot_grupo #(.N(TMR_BYTES)) u_snap_tmr (
    .clk(clk), .rst_n(rst_n), .load(arm_tmr), .d(tmr_live), .q(tmr_snap)
  );

  // While arming, the live byte is returned so it matches the value being captured.
  assign rtc_view = arm_rtc ? rtc_live : rtc_snap;
  assign tmr_view = arm_tmr ? tmr_live : tmr_snap;
`else
  assign rtc_view = rtc_live;
  assign tmr_view = tmr_live;
`endif

  assign clr_status = bus.read_strobe && (bus.port_id == STATUS_PORT);

  always_comb begin
    in_port_d = 8'h00;
    if (bus.port_id == STATUS_PORT) begin
      in_port_d = status_byte(sticky_q);
    end else begin
      case (bus.port_id)
        PORT_SEG_HORA:   in_port_d = rtc_view[0];
        PORT_MIN_HORA:   in_port_d = rtc_view[1];
        PORT_HORA_HORA:  in_port_d = rtc_view[2];
        PORT_DIA_FECHA:  in_port_d = rtc_view[3];
        PORT_MES_FECHA:  in_port_d = rtc_view[4];
        PORT_JAHR_FECHA: in_port_d = rtc_view[5];
        PORT_SEG_TIMER:  in_port_d = tmr_view[0];
        PORT_MIN_TIMER:  in_port_d = tmr_view[1];
        PORT_HORA_TIMER: in_port_d = tmr_view[2];
        PORT_BANDERAS:   in_port_d = banderas_config;
        default:         in_port_d = 8'h00;
      endcase
    end
  end

  // A new pulse outranks a clear on the same edge.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_status) sticky_d = 2'b00;
    if (timer_fin)  sticky_d[BIT_TIMER_FIN] = 1'b1;
    if (alarma)     sticky_d[BIT_ALARMA]    = 1'b1;
    irq_d = |sticky_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_port_q <= 8'h00;
      sticky_q  <= 2'b00;
      irq_q     <= 1'b0;
    end else begin
      in_port_q <= in_port_d;
      sticky_q  <= sticky_d;
      irq_q     <= irq_d;
    end
  end

  assign bus.in_port = in_port_q;
  assign bus.irq     = irq_q;

endmodule

// File: tb/tb_mux_lectura_registros.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural reference.
module tb_mux_lectura_registros;

`ifdef LECTURA_SNAPSHOT_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  logic [7:0] seg_hora, min_hora, hora_hora, dia_fecha, mes_fecha, jahr_fecha;
  logic [7:0] seg_timer, min_timer, hora_timer, banderas_config;
  logic timer_fin, alarma;

  mux_lectura_registros_if bus();

  mux_lectura_registros dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .seg_hora(seg_hora), .min_hora(min_hora), .hora_hora(hora_hora),
    .dia_fecha(dia_fecha), .mes_fecha(mes_fecha), .jahr_fecha(jahr_fecha),
    .seg_timer(seg_timer), .min_timer(min_timer), .hora_timer(hora_timer),
    .banderas_config(banderas_config), .timer_fin(timer_fin), .alarma(alarma)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%02h expected=%02h", nm, act, exp);
    end
  endtask

  // Reference: what the CPU should see, derived from the register map rules.
  logic [7:0] m_rtc [6];
  logic [7:0] m_tmr [3];
  logic [1:0] m_sticky;
  logic [7:0] m_in;

  always @(posedge clk or negedge rst_n) begin : modelo
    logic [7:0] live [16];
    logic [7:0] v;
    int a;
    if (!rst_n) begin
      m_rtc = '{default: 8'h00};
      m_tmr = '{default: 8'h00};
      m_sticky = 2'b00;
      m_in = 8'h00;
    end else begin
      live = '{default: 8'h00};
      live[3] = seg_hora;  live[4] = min_hora;  live[5] = hora_hora;
      live[6] = dia_fecha; live[7] = mes_fecha; live[8] = jahr_fecha;
      live[10] = seg_timer; live[11] = min_timer; live[12] = hora_timer;
      live[13] = banderas_config;
      a = int'(bus.port_id);
      v = 8'h00;
      if (a == 14) v = {6'b0, m_sticky};
      else if (a < 16) begin
        v = live[a];
        if (SNAP) begin
          if (a >= 3 && a <= 8 && !(a == 3 && !bus.read_strobe)) v = m_rtc[a-3];
          if (a >= 10 && a <= 12 && !(a == 10 && !bus.read_strobe)) v = m_tmr[a-10];
          if (a == 3 && !bus.read_strobe) for (int i = 0; i < 6; i++) m_rtc[i] = live[3+i];
          if (a == 10 && !bus.read_strobe) for (int i = 0; i < 3; i++) m_tmr[i] = live[10+i];
        end
      end
      m_in = v;
      if (bus.read_strobe && a == 14) m_sticky = 2'b00;
      if (timer_fin) m_sticky[0] = 1'b1;
      if (alarma)    m_sticky[1] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_in_port", bus.in_port, m_in);
      chk("cyc_irq", {7'b0, bus.irq}, {7'b0, |m_sticky});
    end
  end

  // Two-cycle INPUT: address first, strobe second; data sampled in the strobe cycle.
  task automatic rd(input logic [7:0] addr, output logic [7:0] d);
    @(negedge clk); bus.port_id = addr; bus.read_strobe = 1'b0;
    @(negedge clk); bus.read_strobe = 1'b1; d = bus.in_port;
    @(negedge clk); bus.read_strobe = 1'b0; bus.port_id = 8'h00;
    $display("read port=%02h data=%02h", addr, d);
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    rd(addr, d);
    chk(nm, d, exp);
  endtask

  task automatic pulse_timer_fin();
    @(negedge clk); timer_fin = 1'b1;
    @(negedge clk); timer_fin = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    rst_n = 1'b0;
    bus.port_id = 8'h00; bus.read_strobe = 1'b0;
    {seg_hora, min_hora, hora_hora, dia_fecha, mes_fecha, jahr_fecha} = '0;
    {seg_timer, min_timer, hora_timer, banderas_config} = '0;
    timer_fin = 1'b0; alarma = 1'b0;

    repeat (3) @(negedge clk);
    seg_hora = 8'h77; timer_fin = 1'b1; bus.port_id = 8'h03;
    @(negedge clk);
    chk("reset_in_port", bus.in_port, 8'h00);
    chk("reset_irq", {7'b0, bus.irq}, 8'h00);
    timer_fin = 1'b0; bus.port_id = 8'h00;
    rst_n = 1'b1;
    cmp_en = 1'b1;

    // RTC rolls over between the arm read and the remaining bytes.
    seg_hora = 8'h59; min_hora = 8'h59; hora_hora = 8'h00;
    dia_fecha = 8'h31; mes_fecha = 8'h12; jahr_fecha = 8'h16;
    rd_chk("rtc_arm_03", 8'h03, 8'h59);
    seg_hora = 8'h00; min_hora = 8'h00; hora_hora = 8'h01;
    rd_chk("rtc_04", 8'h04, SNAP ? 8'h59 : 8'h00);
    rd_chk("rtc_05", 8'h05, SNAP ? 8'h00 : 8'h01);
    rd_chk("rtc_06", 8'h06, 8'h31);
    rd_chk("rtc_07", 8'h07, 8'h12);
    rd_chk("rtc_08", 8'h08, 8'h16);

    // Timer snapshot and re-arm.
    seg_timer = 8'h05; min_timer = 8'h10; hora_timer = 8'h00;
    rd_chk("tmr_arm_0a", 8'h0A, 8'h05);
    seg_timer = 8'h06; min_timer = 8'h11; hora_timer = 8'h01;
    rd_chk("tmr_0b", 8'h0B, SNAP ? 8'h10 : 8'h11);
    rd_chk("tmr_0c", 8'h0C, SNAP ? 8'h00 : 8'h01);
    rd_chk("tmr_rearm_0a", 8'h0A, 8'h06);
    rd_chk("tmr_rearm_0b", 8'h0B, 8'h11);
    rd_chk("tmr_rearm_0c", 8'h0C, 8'h01);

    // Sticky timer_fin, then clear through a status read.
    pulse_timer_fin();
    chk("irq_after_pulse", {7'b0, bus.irq}, 8'h01);
    rd_chk("status_set", 8'h0E, 8'h01);
    chk("irq_after_clear", {7'b0, bus.irq}, 8'h00);
    rd_chk("status_cleared", 8'h0E, 8'h00);

    // alarma arrives on the clearing edge and must survive it.
    pulse_timer_fin();
    @(negedge clk); bus.port_id = 8'h0E; bus.read_strobe = 1'b0;
    @(negedge clk); bus.read_strobe = 1'b1; alarma = 1'b1; d = bus.in_port;
    chk("status_before_race", d, 8'h01);
    @(negedge clk); bus.read_strobe = 1'b0; alarma = 1'b0; bus.port_id = 8'h00;
    chk("irq_race_kept", {7'b0, bus.irq}, 8'h01);
    rd_chk("status_race", 8'h0E, 8'h02);
    chk("irq_race_cleared", {7'b0, bus.irq}, 8'h00);

    // Unmapped addresses and live configuration flags.
    banderas_config = 8'hA5;
    rd_chk("unmapped_09", 8'h09, 8'h00);
    rd_chk("unmapped_0f", 8'h0F, 8'h00);
    rd_chk("unmapped_ff", 8'hFF, 8'h00);
    rd_chk("banderas_a5", 8'h0D, 8'hA5);
    banderas_config = 8'h3C;
    rd_chk("banderas_3c", 8'h0D, 8'h3C);

    // Reset in the middle of a strobe cycle.
    min_hora = 8'h42;
    rd_chk("pre_reset_arm", 8'h03, seg_hora);
    pulse_timer_fin();
    chk("irq_before_reset", {7'b0, bus.irq}, 8'h01);
    @(negedge clk); bus.port_id = 8'h04; bus.read_strobe = 1'b0;
    @(negedge clk); bus.read_strobe = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_in_port", bus.in_port, 8'h00);
    chk("async_reset_irq", {7'b0, bus.irq}, 8'h00);
    bus.read_strobe = 1'b0; bus.port_id = 8'h00;
    @(negedge clk); rst_n = 1'b1;
    rd_chk("post_reset_04", 8'h04, SNAP ? 8'h00 : 8'h42);
    rd_chk("post_reset_arm", 8'h03, seg_hora);
    rd_chk("post_reset_04_armed", 8'h04, 8'h42);

    // Random traffic, checked every cycle by the reference.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      bus.port_id = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      bus.read_strobe = 1'($urandom_range(0, 1));
      timer_fin = ($urandom_range(0, 7) == 0);
      alarma    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0) begin
        seg_hora = 8'($urandom); min_hora = 8'($urandom); hora_hora = 8'($urandom);
        dia_fecha = 8'($urandom); mes_fecha = 8'($urandom); jahr_fecha = 8'($urandom);
        seg_timer = 8'($urandom); min_timer = 8'($urandom); hora_timer = 8'($urandom);
        banderas_config = 8'($urandom);
      end
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_lectura_registros.md
MUX_LECTURA_REGISTROS -- requirements
Module: mux_lectura_registros

Interface
REQ-001 Parameter: STATUS_PORT, 8'h0E, port_id address of the sticky status register.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 port_id  input  8  PicoBlaze I/O address.
REQ-005 read_strobe  input  1  PicoBlaze read strobe, high in the second cycle of INPUT.
REQ-006 seg_hora, min_hora, hora_hora, dia_fecha, mes_fecha, jahr_fecha  input  8 each  live RTC time/date values.
REQ-007 seg_timer, min_timer, hora_timer  input  8 each  live timer values.
REQ-008 banderas_config  input  8  live configuration flags.
REQ-009 timer_fin, alarma  input  1 each  single-cycle event pulses.
REQ-010 in_port  output  8  registered read data to PicoBlaze.
REQ-011 irq  output  1  high while any sticky status bit is set.

Function
REQ-012 The port map SHALL mirror the write decoder: 03 seg_hora, 04 min_hora, 05 hora_hora, 06 dia_fecha, 07 mes_fecha, 08 jahr_fecha, 0A seg_timer, 0B min_timer, 0C hora_timer, 0D banderas_config, STATUS_PORT status; all other addresses read 8'h00.
REQ-013 in_port SHALL be registered every cycle from port_id, giving 1-cycle latency; in_port must be valid in the cycle read_strobe is high.
REQ-014 Arm cycle: port_id==03 with read_strobe==0 SHALL load the 6-byte RTC snapshot from live inputs on the same edge that in_port loads live seg_hora.
REQ-015 Arm cycle: port_id==0A with read_strobe==0 SHALL load the 3-byte timer snapshot from live inputs on the same edge that in_port loads live seg_timer.
REQ-016 Outside arm cycles, addresses 03–08 and 0A–0C SHALL return snapshot bytes; snapshots hold until the next arm cycle.
REQ-017 Address 0D SHALL always return live banderas_config.
REQ-018 Status byte: bit0 timer_fin sticky, bit1 alarma sticky, bits7:2 zero.
REQ-019 A pulse SHALL set its sticky bit on the next edge.
REQ-020 read_strobe==1 with port_id==STATUS_PORT SHALL clear both sticky bits on that edge.
REQ-021 If a set pulse and a clear occur on the same edge, set SHALL win for that bit.
REQ-022 irq SHALL equal OR of the sticky bits, registered, with no extra delay beyond the sticky register.
REQ-023 A repeated arm cycle (back-to-back reads of 03) SHALL re-snapshot; no other port affects the snapshots.

Reset
REQ-024 rst_n low SHALL asynchronously clear in_port, both snapshots, the sticky bits and irq to 0.
REQ-025 Reset asserted mid-INPUT SHALL abort the read; after release, the first arm cycle behaves normally.

Configuration
REQ-026 With macro LECTURA_SNAPSHOT_EN defined, REQ-014 to REQ-016 SHALL apply.
REQ-027 Without LECTURA_SNAPSHOT_EN, snapshot registers SHALL be absent and every address SHALL return the live value, still registered with 1-cycle latency; the status behaviour is unchanged.

Structure
REQ-028 Port address constants and the status bit positions SHALL reside in shared package registros_pkg, which the write decoder also uses.
REQ-029 Sub-module snapshot_grupo, an N-byte load-enable register bank with async reset, SHALL be instantiated twice: N=6 (RTC) and N=3 (timer).

Verification
REQ-030 Live 00:59:59, 31/12/16; arm 03 then read 03..08 while the RTC rolls to 01:00:00 mid-sequence -> reads 59,59,00,31,12,16.
REQ-031 Arm 0A with timer 00:10:05, then increment live values; read 0B, 0C -> 10, 00; re-arm 0A -> new values returned.
REQ-032 Pulse timer_fin -> irq=1 next cycle and status read returns 8'h01; read_strobe on STATUS_PORT -> status 8'h00, irq=0.
REQ-033 alarma pulse on the same edge as a status clear -> status 8'h02, irq stays 1.
REQ-034 Read 09, 0F, FF -> 8'h00; read 0D -> live banderas_config with no snapshot.
REQ-035 Assert rst_n low during a read_strobe on 04 -> in_port=00 immediately and snapshots=00; rebuild without LECTURA_SNAPSHOT_EN and repeat REQ-030 -> min_hora reads the live value 00.
